// File: rtl/seg7_scan_if.sv
// rtl/seg7_scan_if.sv - display data/control bundle for the multiplexed 7-segment scanner
//
// Purpose: groups the display inputs and the registered segment/select drives
//          of seg7_scan into one interface.
// Signals:
//   i_en      display enable (low blanks everything)
//   i_din     4*NDIG hex nibbles, nibble k = digit k, digit 0 least significant
//   i_dp      per-digit decimal point request, active-high
//   i_blink   per-digit blink request, active-high
//   o_nseg    segment drive, active-low, bit0 = a .. bit6 = g
//   o_ndp     decimal point drive, active-low
//   o_ndigsel digit common select, active-low one-hot
// Modports: master drives the requests and observes the drives (the system
//           side), slave is the scanner itself.
interface seg7_scan_if #(
  parameter int NDIG = 4
);
  logic              i_en;
  logic [4*NDIG-1:0] i_din;
  logic [NDIG-1:0]   i_dp;
  logic [NDIG-1:0]   i_blink;
  logic [6:0]        o_nseg;
  logic              o_ndp;
  logic [NDIG-1:0]   o_ndigsel;

  modport master (
    output i_en, i_din, i_dp, i_blink,
    input  o_nseg, o_ndp, o_ndigsel
  );

  modport slave (
    input  i_en, i_din, i_dp, i_blink,
    output o_nseg, o_ndp, o_ndigsel
  );
endinterface

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - multiplexed hex 7-segment display scanner with per-digit blink
//
// Purpose: time-multiplexes NDIG hex digits onto one set of active-low
//          segment lines. Each digit is selected for SCAN_DIV clocks; the
//          blink phase toggles every BLINK_DIV complete frames. All drives
//          are registered (one clock after the scan state / inputs).
// Ports:
//   i_clk    system clock, all state on the rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      seg7_scan_if.slave (enable, digit data, DP, blink, drives)
// Parameters: NDIG (2..8), SCAN_DIV (>=2), BLINK_DIV (>=1).
// Build option: define SEG7_SCAN_LZB_EN to compile in leading-zero blanking
//               (digit k>=1 dark when it and every higher nibble are zero).
module seg7_scan #(
  parameter int NDIG      = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 64
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  seg7_scan_if.slave  bus
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NDIG);
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [PW-1:0]   r_presc;
  logic [IW-1:0]   r_idx;
  logic [FW-1:0]   r_frame;
  logic            r_phase;
  logic [6:0]      r_nseg;
  logic            r_ndp;
  logic [NDIG-1:0] r_ndigsel;

  logic            w_presc_tc;
  logic            w_idx_wrap;
  logic            w_frame_tc;
  logic [3:0]      w_nib;
  logic            w_dp;
  logic            w_blink;
  logic            w_lzb;
  logic            w_dark;
  logic [NDIG-1:0] w_sel;
  logic [6:0]      w_seg;

  // gfedcba, active-low
  function automatic logic [6:0] f_hex(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1011000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  assign w_presc_tc = (r_presc == PW'(SCAN_DIV - 1));
  assign w_idx_wrap = (r_idx == IW'(NDIG - 1));
  assign w_frame_tc = (r_frame == FW'(BLINK_DIV - 1));

  // Scan timebase: prescaler -> digit index -> frame counter -> blink phase.
  // None of it looks at i_en, so blanking never disturbs scan timing.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_frame <= '0;
      r_phase <= 1'b0;
    end else if (w_presc_tc) begin
      r_presc <= '0;
      if (w_idx_wrap) begin
        r_idx <= '0;
        if (w_frame_tc) begin
          r_frame <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_frame <= r_frame + FW'(1);
        end
      end else begin
        r_idx <= r_idx + IW'(1);
      end
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Select the current digit's nibble/DP/blink with an explicit compare mux
  // (avoids index arithmetic that could overflow the narrow index width).
  always_comb begin
    w_nib   = 4'h0;
    w_dp    = 1'b0;
    w_blink = 1'b0;
    w_sel   = '1;
    for (int k = 0; k < NDIG; k++) begin
      if (r_idx == IW'(k)) begin
        w_nib    = bus.i_din[4*k +: 4];
        w_dp     = bus.i_dp[k];
        w_blink  = bus.i_blink[k];
        w_sel[k] = 1'b0;
      end
    end
  end

`ifdef SEG7_SCAN_LZB_EN
  // Walk from the most significant nibble down; w_lzb is set when the
  // current digit and everything above it are zero. Digit 0 always shows.
  always_comb begin
    logic hi_zero;
    hi_zero = 1'b1;
    w_lzb   = 1'b0;
    for (int k = NDIG - 1; k >= 0; k--) begin
      hi_zero = hi_zero & (bus.i_din[4*k +: 4] == 4'h0);
      if ((k != 0) && (r_idx == IW'(k))) begin
        w_lzb = hi_zero;
      end
    end
  end
`else
  assign w_lzb = 1'b0;
`endif

  assign w_dark = r_phase & w_blink;
  assign w_seg  = (w_dark | w_lzb) ? 7'h7F : f_hex(w_nib);

  // Select and segments come from the same r_idx in the same edge, so a
  // digit change can never show the old select with new segments.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_nseg    <= 7'h7F;
      r_ndp     <= 1'b1;
      r_ndigsel <= '1;
    end else if (!bus.i_en) begin
      r_nseg    <= 7'h7F;
      r_ndp     <= 1'b1;
      r_ndigsel <= '1;
    end else begin
      r_nseg    <= w_seg;
      r_ndp     <= ~(w_dp & ~w_dark);
      r_ndigsel <= w_sel;
    end
  end

  assign bus.o_nseg    = r_nseg;
  assign bus.o_ndp     = r_ndp;
  assign bus.o_ndigsel = r_ndigsel;

endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - randomized model-checked bench for seg7_scan
module tb_seg7_scan;
  localparam int NDIG = 4;
  localparam int SD   = 4;
  localparam int BD   = 2;
  localparam logic [11:0] OFF = {7'h7F, 1'b1, 4'hF};

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   cnt;          // clock edges since reset release
  logic [11:0] exp_v;
  logic [6:0]  seg_tbl [16];

  seg7_scan_if #(.NDIG(NDIG)) bus ();

  seg7_scan #(.NDIG(NDIG), .SCAN_DIV(SD), .BLINK_DIV(BD)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    seg_tbl[0]  = 7'b1000000; seg_tbl[1]  = 7'b1111001;
    seg_tbl[2]  = 7'b0100100; seg_tbl[3]  = 7'b0110000;
    seg_tbl[4]  = 7'b0011001; seg_tbl[5]  = 7'b0010010;
    seg_tbl[6]  = 7'b0000010; seg_tbl[7]  = 7'b1011000;
    seg_tbl[8]  = 7'b0000000; seg_tbl[9]  = 7'b0010000;
    seg_tbl[10] = 7'b0001000; seg_tbl[11] = 7'b0000011;
    seg_tbl[12] = 7'b1000110; seg_tbl[13] = 7'b0100001;
    seg_tbl[14] = 7'b0000110; seg_tbl[15] = 7'b0001110;
  end

  // Expected drives for scan time m (clocks since reset) with given inputs.
  function automatic logic [11:0] model(input int m, input logic en,
                                        input logic [15:0] din,
                                        input logic [3:0] dp,
                                        input logic [3:0] blink);
    int idx;
    int phase;
    logic [6:0] seg;
    logic ndp;
    logic [3:0] sel;
    logic dark;
    idx   = (m / SD) % NDIG;
    phase = ((m / (SD * NDIG)) / BD) % 2;
    if (!en) return OFF;
    sel = 4'hF;
    sel[idx] = 1'b0;
    dark = (phase == 1) && blink[idx];
    seg = seg_tbl[(din >> (4 * idx)) & 16'hF];
`ifdef SEG7_SCAN_LZB_EN
    if (idx >= 1 && (din >> (4 * idx)) == 16'h0) seg = 7'h7F;
`endif
    if (dark) seg = 7'h7F;
    ndp = dark ? 1'b1 : ~dp[idx];
    return {seg, ndp, sel};
  endfunction

  // Per-cycle compare against the model.
  initial begin
    cnt = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        exp_v = OFF;
        cnt   = 0;
      end else begin
        exp_v = model(cnt, bus.i_en, bus.i_din, bus.i_dp, bus.i_blink);
        cnt++;
      end
      #1;
      n_cmp++;
      if ({bus.o_nseg, bus.o_ndp, bus.o_ndigsel} !== exp_v) begin
        n_err++;
        $display("FAIL cycle_model t=%0t got nseg=%b ndp=%b sel=%b want nseg=%b ndp=%b sel=%b",
                 $time, bus.o_nseg, bus.o_ndp, bus.o_ndigsel,
                 exp_v[11:5], exp_v[4], exp_v[3:0]);
      end
    end
  end

  task automatic check_lit(input string name, input logic [6:0] seg,
                           input logic ndp, input logic [3:0] sel);
    n_cmp++;
    if ({bus.o_nseg, bus.o_ndp, bus.o_ndigsel} !== {seg, ndp, sel}) begin
      n_err++;
      $display("FAIL %s got nseg=%b ndp=%b sel=%b want nseg=%b ndp=%b sel=%b",
               name, bus.o_nseg, bus.o_ndp, bus.o_ndigsel, seg, ndp, sel);
    end
  endtask

  // Wait (at a negedge) until the outputs show digit k; phase -1 = any phase.
  task automatic wait_slot(input int k, input int ph);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (cnt > 0 && ((cnt - 1) / SD) % NDIG == k &&
          (ph < 0 || (((cnt - 1) / (SD * NDIG)) / BD) % 2 == ph))
        hit = 1'b1;
    end
    if (!hit) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_slot timeout got no slot want digit %0d phase %0d", k, ph);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.i_en = 1'b0;
    bus.i_din = '0;
    bus.i_dp = '0;
    bus.i_blink = '0;
    repeat (3) @(negedge clk);
    check_lit("reset_state", 7'h7F, 1'b1, 4'hF);

    // Basic scan of 1234
    bus.i_en  = 1'b1;
    bus.i_din = 16'h1234;
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      @(negedge clk);
      if (e == 1)  check_lit("scan_d0_4", 7'b0011001, 1'b1, 4'b1110);
      if (e == 5)  check_lit("scan_d1_3", 7'b0110000, 1'b1, 4'b1101);
      if (e == 9)  check_lit("scan_d2_2", 7'b0100100, 1'b1, 4'b1011);
      if (e == 13) check_lit("scan_d3_1", 7'b1111001, 1'b1, 4'b0111);
    end

    // Hex letters and DP on digit 2
    bus.i_din = 16'hABCF;
    bus.i_dp  = 4'b0100;
    wait_slot(2, -1);
    check_lit("hex_b_dp", 7'b0000011, 1'b0, 4'b1011);
    wait_slot(3, -1);
    check_lit("hex_a", 7'b0001000, 1'b1, 4'b0111);
    wait_slot(0, -1);
    check_lit("hex_f", 7'b0001110, 1'b1, 4'b1110);

    // Blink on digit 0
    bus.i_din   = 16'h8888;
    bus.i_dp    = 4'b0000;
    bus.i_blink = 4'b0001;
    wait_slot(0, 1);
    check_lit("blink_off", 7'h7F, 1'b1, 4'b1110);
    wait_slot(1, 1);
    check_lit("blink_other", 7'b0000000, 1'b1, 4'b1101);
    wait_slot(0, 0);
    check_lit("blink_on", 7'b0000000, 1'b1, 4'b1110);

    // EN low pulse mid-slot
    wait_slot(1, -1);
    @(negedge clk);
    bus.i_en = 1'b0;
    @(negedge clk);
    check_lit("en_off", 7'h7F, 1'b1, 4'hF);
    repeat (2) @(negedge clk);
    bus.i_en = 1'b1;
    repeat (8) @(negedge clk);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      bus.i_din   = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
      bus.i_dp    = 4'($urandom);
      bus.i_blink = 4'($urandom);
      bus.i_en    = ($urandom_range(0, 7) != 0);
    end

    // Leading zeros
    bus.i_en    = 1'b1;
    bus.i_dp    = 4'b0000;
    bus.i_blink = 4'b0000;
    bus.i_din   = 16'h0070;
    wait_slot(3, -1);
`ifdef SEG7_SCAN_LZB_EN
    check_lit("lz_d3", 7'h7F, 1'b1, 4'b0111);
`else
    check_lit("lz_d3", 7'b1000000, 1'b1, 4'b0111);
`endif
    wait_slot(1, -1);
    check_lit("lz_d1_7", 7'b1011000, 1'b1, 4'b1101);
    wait_slot(0, -1);
    check_lit("lz_d0_0", 7'b1000000, 1'b1, 4'b1110);
    bus.i_din = 16'h0000;
    wait_slot(1, -1);
`ifdef SEG7_SCAN_LZB_EN
    check_lit("zero_d1", 7'h7F, 1'b1, 4'b1101);
`else
    check_lit("zero_d1", 7'b1000000, 1'b1, 4'b1101);
`endif

    // Asynchronous reset at digit 2
    bus.i_din = 16'h1234;
    wait_slot(2, -1);
    #2;
    rst_n = 1'b0;
    #1;
    check_lit("async_reset", 7'h7F, 1'b1, 4'hF);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_lit("restart_d0", 7'b0011001, 1'b1, 4'b1110);
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter NDIG, default 4: number of multiplexed digits, range 2..8.
REQ-002 Parameter SCAN_DIV, default 50000: CLK cycles each digit is driven, minimum 2.
REQ-003 Parameter BLINK_DIV, default 64: full scan frames per blink half-period, minimum 1.
REQ-004 CLK  in  1  system clock, all state on rising edge.
REQ-005 nRST  in  1  reset, asynchronous assert, active-low.
REQ-006 EN  in  1  display enable; low forces all outputs off.
REQ-007 DIN  in  4*NDIG  hex digit values; DIN[4k+3:4k] is digit k, where digit 0 is least significant.
REQ-008 DP  in  NDIG  decimal point request per digit, active-high.
REQ-009 BLINK  in  NDIG  blink request per digit, active-high.
REQ-010 nSEG  out  7  segment drive, active-low; bit 0 = a through bit 6 = g.
REQ-011 nDP  out  1  decimal point drive, active-low.
REQ-012 nDIGSEL  out  NDIG  digit common select, active-low one-hot.

Function
REQ-013 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; at the terminal count the digit index SHALL advance by one, wrapping NDIG-1 -> 0.
REQ-014 Each index value SHALL therefore be held for exactly SCAN_DIV cycles; a full frame is NDIG*SCAN_DIV cycles.
REQ-015 All outputs SHALL be registered, with 1 cycle latency from index/DIN/DP/BLINK/EN to outputs; no combinational input-to-output path.
REQ-016 nDIGSEL SHALL assert only the bit of the current index, with exactly one bit low whenever display is on.
REQ-017 nSEG SHALL decode the selected nibble per the full hex table (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1011000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-018 nDP SHALL be low when DP[index]=1 and the digit is not blink-blanked.
REQ-019 Blink phase SHALL toggle after every BLINK_DIV complete frames (index wrap NDIG-1 -> 0).
REQ-020 When blink phase=1 and BLINK[index]=1, nSEG=1111111 and nDP=1; nDIGSEL stays asserted.
REQ-021 EN=0 SHALL drive nSEG=1111111, nDP=1, nDIGSEL all-ones on the next cycle; prescaler, index and blink phase keep running.
REQ-022 DIN/DP/BLINK changes mid-slot SHALL appear on the next cycle without disturbing scan timing.
REQ-023 Digit transition: in the cycle the index advances, nDIGSEL and nSEG SHALL update in the same edge, and no cycle shows the old select with the new segments.

Reset
REQ-024 nRST low SHALL asynchronously set prescaler=0, index=0, blink phase=0, blink frame counter=0, nSEG=1111111, nDP=1, nDIGSEL all-ones.
REQ-025 After nRST deassertion, the first output update SHALL be on the next rising CLK edge with index 0; reset mid-frame restarts at digit 0.

Configuration
REQ-026 Macro SEG7_SCAN_LZB_EN SHALL compile in leading-zero blanking.
REQ-027 With the macro defined, digit k (k>=1) SHALL show nSEG=1111111 when its nibble and all more-significant nibbles are 0; digit 0 is never blanked, and DP is unaffected.
REQ-028 Without the macro, all digits SHALL be decoded per REQ-017, and no blanking logic SHALL be present.

Verification (NDIG=4, SCAN_DIV=4, BLINK_DIV=2)
REQ-029 Reset then EN=1, DIN=16'h1234 -> nDIGSEL cycles 1110,1101,1011,0111 every 4 cycles, nSEG = 4,3,2,1 codes per REQ-017.
REQ-030 DIN=16'hABCF, DP=4'b0100 -> hex codes A..F correct, nDP low only while nDIGSEL=1011.
REQ-031 BLINK=4'b0001, DIN=16'h8888 -> digit 0 shows 0000000 for frames 0-1, 1111111 for frames 2-3, then repeats; other digits unaffected.
REQ-032 EN pulsed low for 3 cycles mid-slot -> all outputs off 1 cycle later; on return, index matches uninterrupted scan timing.
REQ-033 nRST asserted at index 2 -> outputs off immediately without a clock; after release, scan resumes at digit 0.
REQ-034 With SEG7_SCAN_LZB_EN, DIN=16'h0070 -> digits 3 and 2 blank, digit 1 shows 7, digit 0 shows 0; DIN=16'h0000 -> only digit 0 lit.
